// File: rtl/types.sv
// Shared types for the UART transmit path.
// Fixed-width aliases plus the transmit FSM state encoding.
package types;

    typedef logic [2:0]  u3;
    typedef logic [7:0]  u8;
    typedef logic [15:0] u16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/serial_transmitter_if.sv
// Host-side bundle of the UART transmitter: byte push, FIFO status, line.
// master = host logic, slave = transmitter.
interface serial_transmitter_if #(
    parameter int DEPTH = 512
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    din;
    logic          full;
    logic          empty;
    logic [CW-1:0] data_count;
    logic          busy;
    logic          TX;

    modport master (
        output wr_en, din,
        input  full, empty, data_count, busy, TX
    );

    modport slave (
        input  wr_en, din,
        output full, empty, data_count, busy, TX
    );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data and a one-cycle valid strobe.
// Writes while full and reads while empty are ignored.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     data_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign data_count = r_count;
    assign dout       = r_dout;
    assign valid      = r_valid;
    assign w_wr       = wr_en && !full;
    assign w_rd       = rd_en && !empty;

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_wr) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_rd) begin
                r_rptr <= next_ptr(r_rptr);
                r_dout <= r_mem[r_rptr];
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/serial_transmitter.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, CLK_IN/BAUD clocks per bit.
// A one-byte prefetch register lets queued frames leave with no idle gap.
module serial_transmitter
    import types::*;
#(
    parameter int CLK_IN = 0,
    parameter int BAUD   = 0,
    parameter int DEPTH  = 512
) (
    input  logic                clk,
    input  logic                rst,
    serial_transmitter_if.slave bus
);
    localparam int BIT_CYCLES = (BAUD > 0) ? CLK_IN / BAUD : 0;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam u16 LAST       = u16'(BIT_CYCLES - 1);

    if (BIT_CYCLES < 2 || BIT_CYCLES > 65535) begin : g_bad_rate
        $error("serial_transmitter: CLK_IN/BAUD must be in 2..65535");
    end

    tx_state_t     r_state;
    u16            r_bit_cnt;
    u3             r_bit_idx;
    u8             r_shift;
    u8             r_hold_byte;
    logic          r_hold_valid;
    logic          r_rd_pending;
    logic          r_tx;

    tx_state_t     w_state_n;
    u16            w_bit_cnt_n;
    u3             w_bit_idx_n;
    u8             w_shift_n;
    u8             w_hold_byte_n;
    logic          w_hold_valid_n;
    logic          w_rd_pending_n;
    logic          w_tx_n;
    logic          w_bit_end;

    logic          w_rd_en;
    u8             w_dout;
    logic          w_valid;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srst       (rst),
        .wr_en      (bus.wr_en),
        .din        (bus.din),
        .rd_en      (w_rd_en),
        .dout       (w_dout),
        .valid      (w_valid),
        .full       (w_full),
        .empty      (w_empty),
        .data_count (w_count)
    );

    assign w_rd_en = !rst && !r_hold_valid && !r_rd_pending && !w_empty;
    assign w_bit_end = (r_bit_cnt == LAST);

    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.data_count = w_count;
    assign bus.TX         = r_tx;
    assign bus.busy       = !rst && ((r_state != IDLE) || r_hold_valid ||
                                     r_rd_pending || !w_empty);

    // Next-state: prefetch bookkeeping, baud counter, frame FSM, line level.
    always_comb begin
        w_state_n      = r_state;
        w_bit_cnt_n    = r_bit_cnt;
        w_bit_idx_n    = r_bit_idx;
        w_shift_n      = r_shift;
        w_hold_byte_n  = r_hold_byte;
        w_hold_valid_n = r_hold_valid;
        w_rd_pending_n = r_rd_pending;
        w_tx_n         = 1'b1;

        if (w_rd_en) begin
            w_rd_pending_n = 1'b1;
        end
        if (w_valid) begin
            w_hold_byte_n  = w_dout;
            w_hold_valid_n = 1'b1;
            w_rd_pending_n = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (r_hold_valid) begin
                    w_shift_n      = r_hold_byte;
                    w_hold_valid_n = 1'b0;
                    w_bit_cnt_n    = '0;
                    w_bit_idx_n    = '0;
                    w_state_n      = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    w_state_n   = DATA;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    w_shift_n   = r_shift >> 1;
                    w_bit_idx_n = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = STOP;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    if (r_hold_valid) begin
                        w_shift_n      = r_hold_byte;
                        w_hold_valid_n = 1'b0;
                        w_bit_idx_n    = '0;
                        w_state_n      = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Line level follows the state being entered, so TX is a flop.
        unique case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shift_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

    // Frame, baud counter and prefetch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_hold_byte  <= '0;
            r_hold_valid <= 1'b0;
            r_rd_pending <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            r_state      <= w_state_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_bit_idx    <= w_bit_idx_n;
            r_shift      <= w_shift_n;
            r_hold_byte  <= w_hold_byte_n;
            r_hold_valid <= w_hold_valid_n;
            r_rd_pending <= w_rd_pending_n;
            r_tx         <= w_tx_n;
        end
    end
endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter at 10 clocks per bit, 16-byte FIFO.
// Outputs are sampled on the falling clock edge.
module tb_serial_transmitter;
    localparam int CLK_IN = 100_000_000;
    localparam int BAUD   = 10_000_000;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_transmitter_if #(.DEPTH(DEPTH)) bus ();

    serial_transmitter #(
        .CLK_IN (CLK_IN),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.din   = v;
    endtask

    task automatic end_push();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int t0, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        t0 = 0;
        while (bus.TX !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.TX === 1'b0) begin
            ok = 1'b1;
            t0 = cyc;
        end
    endtask

    task automatic rx_byte(output logic [7:0] b, output int t0, output bit ok);
        bit f;
        b = '0;
        wait_start(400, t0, f);
        ok = f;
        if (!f) return;
        repeat (5) @(negedge clk);
        if (bus.TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = bus.TX;
        end
        repeat (10) @(negedge clk);
        if (bus.TX !== 1'b1) ok = 1'b0;
    endtask

    task automatic wave_check(input logic [7:0] v, input string tag);
        int   tw;
        int   t0;
        int   mism;
        bit   ok;
        logic exp;
        logic b99;
        push_byte(v);
        end_push();
        tw = cyc;
        wait_start(50, t0, ok);
        check({tag, "_start"}, 32'(ok), 1);
        if (!ok) return;
        check({tag, "_lat"}, t0 - tw, 3);
        mism = 0;
        b99  = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 10)      exp = 1'b0;
            else if (j < 90) exp = v[(j - 10) / 10];
            else             exp = 1'b1;
            if (bus.TX !== exp) mism++;
            if (j == 99) b99 = bus.busy;
        end
        check({tag, "_wave"}, mism, 0);
        check({tag, "_busy_stop"}, 32'(b99), 1);
        @(negedge clk);
        check({tag, "_idle_tx"}, 32'(bus.TX), 1);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] src [20];
        logic [7:0] got [18];
        int         gt  [18];
        bit         gok [18];
        logic [7:0] rb;
        int         rt;
        bit         rk;
        int         vt, vb, ve, vc, nok, lows;

        bus.wr_en = 1'b0;
        bus.din   = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        vt = 0; vb = 0; ve = 0; vc = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.TX !== 1'b1)         vt++;
            if (bus.busy !== 1'b0)       vb++;
            if (bus.empty !== 1'b1)      ve++;
            if (bus.data_count !== '0)   vc++;
        end
        check("rst_tx", vt, 0);
        check("rst_busy", vb, 0);
        check("rst_empty", ve, 0);
        check("rst_count", vc, 0);
        check("rst_full", 32'(bus.full), 0);

        wave_check(8'h55, "b55");
        repeat (20) @(negedge clk);

        push_byte(8'hA3);
        push_byte(8'h0F);
        push_byte(8'hFF);
        end_push();
        src[0] = 8'hA3;
        src[1] = 8'h0F;
        src[2] = 8'hFF;
        nok = 0;
        for (int f = 0; f < 3; f++) begin
            rx_byte(rb, rt, rk);
            got[f] = rb;
            gt[f]  = rt;
            if (rk) nok++;
        end
        check("b2b_frames", nok, 3);
        for (int f = 0; f < 3; f++) begin
            check($sformatf("b2b_byte%0d", f), 32'(got[f]), 32'(src[f]));
        end
        check("b2b_gap01", gt[1] - gt[0], 100);
        check("b2b_gap12", gt[2] - gt[1], 100);
        repeat (6) @(negedge clk);
        check("b2b_busy_end", 32'(bus.busy), 0);
        repeat (20) @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            src[k] = 8'(8'h11 + k * 29);
        end
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (k == 2)  check("cnt_rdwr1", 32'(bus.data_count), 1);
                    if (k == 5)  check("cnt_rdwr2", 32'(bus.data_count), 3);
                    if (k == 17) check("not_full15", 32'(bus.full), 0);
                    if (k == 18) begin
                        check("full_at16", 32'(bus.full), 1);
                        check("cnt_at16", 32'(bus.data_count), 16);
                    end
                    bus.wr_en = 1'b1;
                    bus.din   = src[k];
                end
                @(negedge clk);
                bus.wr_en = 1'b0;
                check("full_hold", 32'(bus.full), 1);
                check("cnt_drop", 32'(bus.data_count), 16);
            end
            begin
                for (int f = 0; f < 18; f++) begin
                    rx_byte(rb, rt, rk);
                    got[f] = rb;
                    gok[f] = rk;
                end
            end
        join
        nok = 0;
        for (int f = 0; f < 18; f++) begin
            if (gok[f]) nok++;
            check($sformatf("burst_byte%0d", f), 32'(got[f]), 32'(src[f]));
        end
        check("burst_frames", nok, 18);
        wait_start(300, rt, rk);
        check("burst_no_extra", 32'(rk), 0);
        check("burst_empty", 32'(bus.empty), 1);
        check("burst_busy", 32'(bus.busy), 0);

        push_byte(8'h3C);
        push_byte(8'h81);
        push_byte(8'h7E);
        end_push();
        wait_start(50, rt, rk);
        check("rst_mid_start", 32'(rk), 1);
        repeat (45) @(negedge clk);
        check("rst_mid_queued", 32'(bus.data_count), 1);
        check("rst_mid_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(bus.TX), 1);
        check("rst_mid_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        check("rst_mid_empty", 32'(bus.empty), 1);
        check("rst_mid_count", 32'(bus.data_count), 0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        vb   = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.TX !== 1'b1)   lows++;
            if (bus.busy !== 1'b0) vb++;
        end
        check("rst_mid_no_frames", lows, 0);
        check("rst_mid_idle_busy", vb, 0);

        wave_check(8'h00, "b00");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

FIFO-buffered 8N1 UART transmitter, the transmit-side counterpart of the UART receive path. Host logic pushes bytes through a write-enable/full interface into an internal `fifo`. The block drains it and serialises each byte LSB-first on `TX` at `CLK_IN/BAUD` clocks per bit. A one-byte prefetch register allows queued bytes to go out back-to-back with no idle gap.

## Interface
- `CLK_IN`, 0: input clock frequency in Hz.
- `BAUD`, 0: line rate in bit/s.
- `DEPTH`, 512: FIFO depth in bytes.
- `BIT_CYCLES` (localparam) = `CLK_IN/BAUD`: clocks per bit, integer division. Elaboration error if < 2 or > 65535.
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: push `din` into the FIFO this cycle; ignored while `full`.
- `din` input 8: byte to send.
- `full` output 1: FIFO full, driven directly from `fifo`.
- `empty` output 1: FIFO empty. The prefetch register is not counted.
- `data_count` output `$clog2(DEPTH)+1`: FIFO occupancy, driven from `fifo`.
- `busy` output 1: high while a frame is on the line, a byte is prefetched, or a FIFO read is pending.
- `TX` output 1: serial line, idle high.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Total frame length 10·`BIT_CYCLES` clocks.
- `fifo #(8, DEPTH)` provides buffering. Its `srst` is tied to `rst`. It returns `dout` with `valid` high on the cycle after `rd_en`.
- Prefetcher:
  - Condition: `!hold_valid && !rd_pending && !empty`.
  - Action: pulse `rd_en` for one cycle and set `rd_pending`.
  - On `valid`: `hold_byte <= dout`, `hold_valid <= 1`, `rd_pending <= 0`.
- FSM states (`tx_state_t`): IDLE, START, DATA, STOP.
  - IDLE: `TX=1`. If `hold_valid`: `shift_reg <= hold_byte`, `hold_valid <= 0`, `bit_cnt <= 0`, `bit_idx <= 0`, go to START.
  - START: `TX=0`. After `BIT_CYCLES` clocks, go to DATA.
  - DATA: `TX=shift_reg[0]`. At the end of each bit, shift right; the bit after `bit_idx==7` ends goes to STOP.
  - STOP: `TX=1`. On the last clock of the stop bit:
    - if `hold_valid`, load `shift_reg` and go straight to START (zero gap);
    - otherwise go to IDLE.
- `bit_cnt` counts 0..`BIT_CYCLES`-1. The bit-end condition is `bit_cnt == BIT_CYCLES-1`, and `bit_cnt` wraps to 0 there.
- `TX` is registered: no combinational path from state decode to the pin.

## Timing
- Reset values: `TX=1`, `busy=0`, FSM=IDLE, `hold_valid=0`, `rd_pending=0`, `shift_reg=0`, `bit_cnt=0`.
  - These apply asynchronously on `rst` assertion.
  - The FIFO clears on the first `clk` edge with `rst` high. `rst` must be held for at least 1 clock.
  - After that edge: `empty=1`, `full=0`, `data_count=0`.
- Latency, empty block:
  - `wr_en` at edge N: FIFO `empty` falls per `fifo` timing.
  - `rd_en` is asserted the cycle `empty` reads 0.
  - `hold_valid` is set 2 edges later.
  - `TX` falls on the following edge.
  - Total from write to start bit ≤ 5 clocks; the bench fixes the exact value from `fifo` latency.
- Back-to-back: with data queued, the next start bit begins on the clock immediately after the last stop-bit clock. There are no extra idle cycles.
- `wr_en` while `full`: the byte is dropped, `full` stays 1, and `data_count` is unchanged.
- Simultaneous `wr_en` and internal `rd_en`: both take effect, and `data_count` is unchanged.
- `rst` mid-frame: `TX` returns to 1 immediately, the frame is truncated, and the prefetched and queued bytes are discarded.
- `busy` falls on the same edge that the FSM enters IDLE with `hold_valid=0`, `rd_pending=0` and `empty=1`.

## Structure
- Add `tx_state_t` (IDLE, START, DATA, STOP) to package `types`, alongside the existing `u3`, `u8` and `u16`. Use `u16` for `bit_cnt`, `u3` for `bit_idx`, and `u8` for `shift_reg` and `hold_byte`.
- Reuse the existing `fifo` as the single sub-module. No new sub-module: the baud counter and FSM stay in one `always_ff` with async reset.

## Test plan
All scenarios use `CLK_IN=100_000_000`, `BAUD=10_000_000` (`BIT_CYCLES=10`) and `DEPTH=16`.
- Reset, then idle for 100 clocks -> `TX=1`, `busy=0`, `empty=1`, `data_count=0` throughout.
- Write 0x55 once -> `TX` low for 10 clocks, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then high. The frame is 100 clocks, and `busy` falls at frame end.
- Write 0xA3, 0x0F, 0xFF in consecutive cycles -> three frames with no idle cycle between the stop and start bits. A line sampler decodes 0xA3, 0x0F, 0xFF.
- Write 20 bytes in consecutive cycles -> `full` asserts, and writes made while `full` is high are absent from the decoded output. The bench predicts the exact surviving bytes from the prefetch/`full` timing and compares order.
- Assert `rst` for 1 clock at clock 45 of a frame carrying 0x3C -> `TX=1` in the same cycle, `busy=0`, `empty=1` after the edge. No further frames appear.
- Write 0x00 -> `TX` low for 90 clocks (start plus 8 data bits), then high for the 10-clock stop bit.
